blade_delay_tuner: RTL

- Synchronous closed-loop tuner for the timing-resilient (Blade-style) pipeline stage.
- Counts completed tokens and the tokens flagged as timing errors (Err1 path) over a fixed window.
- At the end of each window, decides whether to lengthen, shorten or hold the stage's delay-line code.
- Delivers a changed code to the asynchronous pipeline over a four-phase cfg_req/cfg_ack handshake.

---
 rtl/blade_delay_tuner.sv | 129 ++++++++++++
 1 files changed

// File: rtl/blade_delay_tuner.sv
// Closed-loop delay-code tuner for a Blade-style timing-resilient stage: counts Err1 tokens per
// window, steps the delay code up/down/hold, and hands changes over a four-phase req/ack link.
module blade_delay_tuner #(
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned CODE_W      = 4,
  parameter int unsigned CODE_MIN    = 0,
  parameter int unsigned CODE_MAX    = 15,
  parameter int unsigned CODE_INIT   = 8,
  parameter int unsigned HI_THRESH   = 4,
  parameter int unsigned LO_THRESH   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           tok_evt,
  input  logic                           tok_err,
  input  logic                           cfg_ack,
  output logic                           cfg_req,
  output logic [CODE_W-1:0]              dly_code,
  output logic [$clog2(WINDOW+1)-1:0]    err_cnt_last,
  output logic                           win_done,
  output logic                           sat_hi,
  output logic                           busy
);

  localparam int unsigned CntW = $clog2(WINDOW + 1);
  localparam logic [CntW-1:0]   WinLast  = CntW'(WINDOW - 1);
  localparam logic [CODE_W-1:0] CodeMin  = CODE_W'(CODE_MIN);
  localparam logic [CODE_W-1:0] CodeMax  = CODE_W'(CODE_MAX);
  localparam logic [CODE_W-1:0] CodeInit = CODE_W'(CODE_INIT);

  typedef enum logic [2:0] {StIdle, StMeasure, StDecide, StReq, StRelease} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        tok_cnt_q, err_cnt_q, err_cnt_last_q;
  logic [CODE_W-1:0]      dly_code_q, code_next;
  logic                   cfg_req_q, win_done_q, sat_hi_q, busy_q;
  logic                   ack_s, err_hi, err_lo;

  assign ack_s  = sync_q[SYNC_STAGES-1];
  assign err_hi = 32'(err_cnt_last_q) > HI_THRESH;
  assign err_lo = 32'(err_cnt_last_q) <= LO_THRESH;

  always_comb begin
    code_next = dly_code_q;
    if (err_hi && (dly_code_q < CodeMax)) begin
      code_next = dly_code_q + CODE_W'(1);
    end else if (err_lo && (dly_code_q > CodeMin)) begin
      code_next = dly_code_q - CODE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      sync_q         <= '0;
      tok_cnt_q      <= '0;
      err_cnt_q      <= '0;
      err_cnt_last_q <= '0;
      dly_code_q     <= CodeInit;
      cfg_req_q      <= 1'b0;
      win_done_q     <= 1'b0;
      sat_hi_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], cfg_ack};
      win_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tok_cnt_q <= '0;
          err_cnt_q <= '0;
          if (en) state_q <= StMeasure;
        end
        StMeasure: begin
          // A completing window wins over en=0 so the final token is never lost.
          if (tok_evt && (tok_cnt_q == WinLast)) begin
            err_cnt_last_q <= err_cnt_q + CntW'(tok_err);
            tok_cnt_q      <= '0;
            err_cnt_q      <= '0;
            win_done_q     <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= StDecide;
          end else if (!en) begin
            tok_cnt_q <= '0;
            err_cnt_q <= '0;
            state_q   <= StIdle;
          end else if (tok_evt) begin
            tok_cnt_q <= tok_cnt_q + CntW'(1);
            err_cnt_q <= err_cnt_q + CntW'(tok_err);
          end
        end
        StDecide: begin
          sat_hi_q <= err_hi && (dly_code_q == CodeMax);
          if (code_next != dly_code_q) begin
            dly_code_q <= code_next;
            cfg_req_q  <= 1'b1;
            state_q    <= StReq;
          end else begin
            busy_q  <= 1'b0;
            state_q <= en ? StMeasure : StIdle;
          end
        end
        StReq: begin
          if (ack_s) begin
            cfg_req_q <= 1'b0;
            state_q   <= StRelease;
          end
        end
        StRelease: begin
          if (!ack_s) begin
            busy_q  <= 1'b0;
            state_q <= en ? StMeasure : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg_req      = cfg_req_q;
  assign dly_code     = dly_code_q;
  assign err_cnt_last = err_cnt_last_q;
  assign win_done     = win_done_q;
  assign sat_hi       = sat_hi_q;
  assign busy         = busy_q;

endmodule
